// File: rtl/time_nmr_end.sv
// rtl/time_nmr_end.sv - end stage of a time-redundant pipeline: collects tagged copies, votes or compares, reports faults
module time_nmr_end #(
    parameter type DataType    = logic,
    parameter int  IDSize      = 1,
    parameter int  LockTimeout = 4,
    parameter int  CntWidth    = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [1:0]          mode_i,
    input  DataType             data_i,
    input  logic [IDSize-1:0]   id_i,
    input  logic                valid_i,
    output logic                ready_o,
    output DataType             data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                uncorrectable_o,
    output logic                lock_o,
    output logic                fault_detected_o,
    output logic [CntWidth-1:0] fault_count_o,
    input  logic                clear_count_i
);

    localparam int IdleW = $clog2(LockTimeout + 1);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_OUTPUT  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [1:0]          n_q, n_d;
    logic [IdleW-1:0]    idle_q, idle_d;
    DataType             slot_data_q [3];
    DataType             slot_data_d [3];
    logic [IDSize-1:0]   slot_id_q [3];
    logic [IDSize-1:0]   slot_id_d [3];
    DataType             res_data_q, res_data_d;
    logic                res_unc_q, res_unc_d;
    logic                fault_q, fault_d;
    logic [CntWidth-1:0] count_q, count_d;

    logic       bypass;
    logic       id_match;
    logic       accept;
    logic       evaluate;
    logic [1:0] n_eff;
    DataType    vote_data;
    logic       vote_unc;
    logic       vote_fault;
    logic       id_mis;

    // The copy count is taken from mode_i only while no group is in flight.
    assign n_eff    = (cnt_q != 2'd0) ? n_q : ((mode_i == 2'b01) ? 2'd2 : 2'd3);
    assign bypass   = (state_q == ST_COLLECT) && (cnt_q == 2'd0) && (mode_i == 2'b00);
    assign id_match = (cnt_q == 2'd0) || (id_i == slot_id_q[0]);
    assign accept   = (state_q == ST_COLLECT) && !bypass && valid_i && id_match;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        idle_d      = idle_q;
        slot_data_d = slot_data_q;
        slot_id_d   = slot_id_q;
        res_data_d  = res_data_q;
        res_unc_d   = res_unc_q;
        fault_d     = 1'b0;
        count_d     = count_q;
        evaluate    = 1'b0;
        vote_data   = slot_data_q[0];
        vote_unc    = 1'b0;
        vote_fault  = 1'b0;
        id_mis      = 1'b0;

        if (state_q == ST_COLLECT) begin
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    if (cnt_q == 2'(i)) begin
                        slot_data_d[i] = data_i;
                        slot_id_d[i]   = id_i;
                    end
                end
                cnt_d    = cnt_q + 2'd1;
                n_d      = n_eff;
                idle_d   = '0;
                evaluate = (cnt_d == n_eff);
            end else if (cnt_q != 2'd0) begin
                // A foreign ID closes the current group without being consumed.
                if (valid_i) begin
                    evaluate = 1'b1;
                end else begin
                    idle_d   = idle_q + IdleW'(1);
                    evaluate = (idle_d == IdleW'(LockTimeout));
                end
            end
        end else if (ready_i) begin
            cnt_d   = 2'd0;
            state_d = ST_COLLECT;
        end

        vote_data = slot_data_d[0];
        id_mis    = ((cnt_d >= 2'd2) && (slot_id_d[1] != slot_id_d[0])) ||
                    ((cnt_d == 2'd3) && (slot_id_d[2] != slot_id_d[0]));
        case (cnt_d)
            2'd3: begin
                if (slot_data_d[0] == slot_data_d[1]) begin
                    vote_fault = (slot_data_d[2] != slot_data_d[0]);
                end else if (slot_data_d[0] == slot_data_d[2]) begin
                    vote_fault = 1'b1;
                end else if (slot_data_d[1] == slot_data_d[2]) begin
                    vote_data  = slot_data_d[1];
                    vote_fault = 1'b1;
                end else begin
                    vote_unc   = 1'b1;
                    vote_fault = 1'b1;
                end
            end
            2'd2: begin
                if (slot_data_d[0] == slot_data_d[1]) begin
                    vote_fault = (n_d == 2'd3);
                end else begin
                    vote_unc   = 1'b1;
                    vote_fault = 1'b1;
                end
            end
            default: begin
                vote_unc   = 1'b1;
                vote_fault = 1'b1;
            end
        endcase
        vote_fault = vote_fault || id_mis;

        if (evaluate) begin
            state_d    = ST_OUTPUT;
            idle_d     = '0;
            res_data_d = vote_data;
            res_unc_d  = vote_unc;
            fault_d    = vote_fault;
        end

        if (clear_count_i) begin
            count_d = '0;
        end else if (fault_d && (count_q != {CntWidth{1'b1}})) begin
            count_d = count_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_COLLECT;
            cnt_q      <= 2'd0;
            n_q        <= 2'd3;
            idle_q     <= '0;
            res_data_q <= '0;
            res_unc_q  <= 1'b0;
            fault_q    <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                slot_data_q[i] <= '0;
                slot_id_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            idle_q      <= idle_d;
            res_data_q  <= res_data_d;
            res_unc_q   <= res_unc_d;
            fault_q     <= fault_d;
            count_q     <= count_d;
            slot_data_q <= slot_data_d;
            slot_id_q   <= slot_id_d;
        end
    end

    always_comb begin
        if (bypass) begin
            data_o          = data_i;
            valid_o         = valid_i;
            ready_o         = ready_i;
            uncorrectable_o = 1'b0;
            lock_o          = 1'b0;
        end else begin
            data_o          = res_data_q;
            valid_o         = (state_q == ST_OUTPUT);
            ready_o         = (state_q == ST_COLLECT) && id_match;
            uncorrectable_o = res_unc_q;
            lock_o          = ((state_q == ST_COLLECT) && (cnt_q != 2'd0)) ||
                              ((state_q == ST_OUTPUT) && !ready_i);
        end
    end

    assign fault_detected_o = fault_q;
    assign fault_count_o    = count_q;

endmodule

// File: tb/tb_time_nmr_end.sv
// tb/tb_time_nmr_end.sv - self-checking bench for time_nmr_end
module tb_time_nmr_end;

    logic       clk;
    logic       rst_ni;
    logic [1:0] mode_i;
    logic [7:0] data_i;
    logic       id_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       uncorrectable_o;
    logic       lock_o;
    logic       fault_detected_o;
    logic [7:0] fault_count_o;
    logic       clear_count_i;

    int n_vec;
    int n_err;
    int model_cnt;

    time_nmr_end #(
        .DataType   (logic [7:0]),
        .IDSize     (1),
        .LockTimeout(4),
        .CntWidth   (8)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .mode_i          (mode_i),
        .data_i          (data_i),
        .id_i            (id_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .uncorrectable_o (uncorrectable_o),
        .lock_o          (lock_o),
        .fault_detected_o(fault_detected_o),
        .fault_count_o   (fault_count_o),
        .clear_count_i   (clear_count_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] mode;
        int         k;
        logic [7:0] d0, d1, d2;
        logic       id;
        int         hold;
        logic [7:0] ed;
        logic       eu;
        logic       ef;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_fault();
        if (model_cnt < 255) model_cnt++;
    endfunction

    // Reference: a strict majority of at least two equal copies is correctable.
    function automatic void ref_vote(input int n, input int k, input logic [7:0] d [3],
                                     output logic [7:0] od, output logic u, output logic f);
        int best, bestc, c;
        best = 0;
        bestc = 0;
        for (int i = 0; i < k; i++) begin
            c = 0;
            for (int j = 0; j < k; j++) if (d[j] == d[i]) c++;
            if (c > bestc) begin
                bestc = c;
                best = i;
            end
        end
        u  = !(bestc >= 2 && 2 * bestc > k);
        od = u ? d[0] : d[best];
        f  = u || (bestc != k) || (k < n);
    endfunction

    task automatic run_group(input logic [1:0] mode, input int k,
                             input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                             input logic id, input int hold,
                             input logic [7:0] ed, input logic eu, input logic ef,
                             input bit scramble, input string tag);
        logic [7:0] dv [3];
        int n, lat, exp_lat;
        dv[0] = d0;
        dv[1] = d1;
        dv[2] = d2;
        n = (mode == 2'b01) ? 2 : 3;
        exp_lat = (k == n) ? 0 : 4;
        mode_i  = mode;
        ready_i = 1'b0;
        for (int i = 0; i < k; i++) begin
            valid_i = 1'b1;
            data_i  = dv[i];
            id_i    = id;
            #1;
            chk($sformatf("%s ready_o copy%0d", tag, i), ready_o, 1);
            chk($sformatf("%s valid_o early copy%0d", tag, i), valid_o, 0);
            tick();
            if (scramble && i == 0) mode_i = 2'($urandom_range(0, 3));
        end
        valid_i = 1'b0;
        #1;
        lat = 0;
        while (!valid_o && lat < 20) begin
            tick();
            lat++;
        end
        chk($sformatf("%s latency", tag), lat, exp_lat);
        chk($sformatf("%s data_o", tag), data_o, ed);
        chk($sformatf("%s uncorrectable_o", tag), uncorrectable_o, eu);
        chk($sformatf("%s fault_detected_o", tag), fault_detected_o, ef);
        if (ef) model_fault();
        chk($sformatf("%s fault_count_o", tag), fault_count_o, model_cnt);
        chk($sformatf("%s lock_o held", tag), lock_o, 1);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk($sformatf("%s valid_o hold%0d", tag, h), valid_o, 1);
            chk($sformatf("%s data_o hold%0d", tag, h), data_o, ed);
            chk($sformatf("%s lock_o hold%0d", tag, h), lock_o, 1);
            chk($sformatf("%s fault pulse hold%0d", tag, h), fault_detected_o, 0);
        end
        ready_i = 1'b1;
        #1;
        chk($sformatf("%s lock_o on ready", tag), lock_o, 0);
        tick();
        chk($sformatf("%s valid_o after handshake", tag), valid_o, 0);
        ready_i = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_cnt = 0;
        rst_ni = 1'b0;
        mode_i = 2'b10;
        data_i = '0;
        id_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        clear_count_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_o", valid_o, 0);
        chk("reset ready_o", ready_o, 1);
        chk("reset lock_o", lock_o, 0);
        chk("reset fault_detected_o", fault_detected_o, 0);
        chk("reset fault_count_o", fault_count_o, 0);
        chk("reset uncorrectable_o", uncorrectable_o, 0);
        chk("reset data_o", data_o, 0);
        rst_ni = 1'b1;
        tick();

        //            mode   k  d0     d1     d2     id    hold ed     eu    ef
        tbl[0]  = '{2'b10, 3, 8'hA5, 8'hA5, 8'hA5, 1'b0, 0, 8'hA5, 1'b0, 1'b0};
        tbl[1]  = '{2'b10, 3, 8'h05, 8'h07, 8'h05, 1'b0, 1, 8'h05, 1'b0, 1'b1};
        tbl[2]  = '{2'b10, 3, 8'h01, 8'h02, 8'h03, 1'b1, 0, 8'h01, 1'b1, 1'b1};
        tbl[3]  = '{2'b10, 3, 8'h07, 8'h05, 8'h05, 1'b0, 0, 8'h05, 1'b0, 1'b1};
        tbl[4]  = '{2'b01, 2, 8'h04, 8'h09, 8'h00, 1'b0, 5, 8'h04, 1'b1, 1'b1};
        tbl[5]  = '{2'b01, 2, 8'h06, 8'h06, 8'h00, 1'b1, 0, 8'h06, 1'b0, 1'b0};
        tbl[6]  = '{2'b10, 1, 8'h33, 8'h00, 8'h00, 1'b0, 0, 8'h33, 1'b1, 1'b1};
        tbl[7]  = '{2'b10, 2, 8'h08, 8'h08, 8'h00, 1'b0, 2, 8'h08, 1'b0, 1'b1};
        tbl[8]  = '{2'b11, 3, 8'h02, 8'h02, 8'h09, 1'b1, 0, 8'h02, 1'b0, 1'b1};
        tbl[9]  = '{2'b01, 1, 8'h44, 8'h00, 8'h00, 1'b0, 0, 8'h44, 1'b1, 1'b1};
        tbl[10] = '{2'b11, 2, 8'h01, 8'h02, 8'h00, 1'b1, 1, 8'h01, 1'b1, 1'b1};
        for (int t = 0; t < 11; t++) begin
            run_group(tbl[t].mode, tbl[t].k, tbl[t].d0, tbl[t].d1, tbl[t].d2, tbl[t].id,
                      tbl[t].hold, tbl[t].ed, tbl[t].eu, tbl[t].ef, 1'b0, $sformatf("tbl%0d", t));
        end

        // ID change closes a partial group; the new element waits for the handshake.
        mode_i = 2'b10;
        valid_i = 1'b1; data_i = 8'h11; id_i = 1'b0;
        tick();
        tick();
        data_i = 8'h22; id_i = 1'b1;
        #1;
        chk("idmis ready_o low", ready_o, 0);
        chk("idmis lock_o", lock_o, 1);
        tick();
        chk("idmis valid_o", valid_o, 1);
        chk("idmis data_o", data_o, 8'h11);
        chk("idmis uncorrectable_o", uncorrectable_o, 0);
        chk("idmis fault_detected_o", fault_detected_o, 1);
        model_fault();
        chk("idmis fault_count_o", fault_count_o, model_cnt);
        chk("idmis ready_o in output", ready_o, 0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        #1;
        chk("idmis new ready_o", ready_o, 1);
        chk("idmis new valid_o", valid_o, 0);
        tick();
        tick();
        tick();
        valid_i = 1'b0;
        #1;
        chk("idmis Y valid_o", valid_o, 1);
        chk("idmis Y data_o", data_o, 8'h22);
        chk("idmis Y fault", fault_detected_o, 0);
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;

        // Bypass is purely combinational.
        mode_i = 2'b00;
        valid_i = 1'b1; data_i = 8'h5A; ready_i = 1'b0;
        #1;
        chk("bypass valid_o", valid_o, 1);
        chk("bypass data_o", data_o, 8'h5A);
        chk("bypass ready_o low", ready_o, 0);
        chk("bypass lock_o", lock_o, 0);
        chk("bypass uncorrectable_o", uncorrectable_o, 0);
        ready_i = 1'b1;
        #1;
        chk("bypass ready_o high", ready_o, 1);
        tick();
        valid_i = 1'b0;
        #1;
        chk("bypass valid_o low", valid_o, 0);
        chk("bypass fault", fault_detected_o, 0);
        ready_i = 1'b0;

        // Reset mid-group drops the stored copy.
        mode_i = 2'b10;
        valid_i = 1'b1; data_i = 8'h77; id_i = 1'b0;
        tick();
        valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("midreset lock_o", lock_o, 0);
        chk("midreset fault_count_o", fault_count_o, 0);
        model_cnt = 0;
        tick();
        rst_ni = 1'b1;
        tick();
        run_group(2'b10, 3, 8'h03, 8'h03, 8'h03, 1'b0, 0, 8'h03, 1'b0, 1'b0, 1'b0, "after_reset");

        // Randomized groups against the reference vote.
        for (int r = 0; r < 150; r++) begin
            logic [1:0] m;
            logic [7:0] rd [3];
            logic [7:0] ed;
            logic eu, ef;
            int n, k;
            m = 2'($urandom_range(1, 3));
            n = (m == 2'b01) ? 2 : 3;
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : n;
            for (int i = 0; i < 3; i++) rd[i] = 8'($urandom_range(0, 3));
            ref_vote(n, k, rd, ed, eu, ef);
            run_group(m, k, rd[0], rd[1], rd[2], 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      ed, eu, ef, 1'b1, $sformatf("rnd%0d", r));
        end

        // Saturation and clear.
        mode_i = 2'b01;
        ready_i = 1'b1;
        id_i = 1'b0;
        for (int s = 0; s < 300; s++) begin
            valid_i = 1'b1; data_i = 8'h01;
            tick();
            data_i = 8'h02;
            tick();
            valid_i = 1'b0;
            model_fault();
            tick();
        end
        chk("saturated fault_count_o", fault_count_o, model_cnt);
        chk("saturated at 255", fault_count_o, 255);
        clear_count_i = 1'b1;
        tick();
        clear_count_i = 1'b0;
        chk("clear fault_count_o", fault_count_o, 0);
        valid_i = 1'b1; data_i = 8'h01;
        tick();
        data_i = 8'h02;
        clear_count_i = 1'b1;
        tick();
        clear_count_i = 1'b0;
        valid_i = 1'b0;
        chk("clear wins fault pulse", fault_detected_o, 1);
        chk("clear wins count", fault_count_o, 0);
        tick();
        chk("clear wins pulse ends", fault_detected_o, 0);
        ready_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
